// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter: round-robin front end for the shared sequential ALU.
// Grants one of N requesters, latches its operands, pulses the ALU start,
// waits for the done pulse under a watchdog and returns the result.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-low reset
//   req_valid/req_ready per-requester handshake, ready is a one-hot grant
//   req_op/req_a/req_b  packed per-requester op (2b) and operands (8b each)
//   alu_begin           one-cycle start pulse to the ALU
//   alu_op/alu_x/alu_y  latched op and operands for the ALU
//   alu_end/alu_res     ALU done pulse and 16-bit result
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_data     served requester index and result
//   rsp_err             timeout or divide-by-zero
//   busy                high whenever the FSM is not idle

module alu_request_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [2*N-1:0] req_op,
    input  logic [8*N-1:0] req_a,
    input  logic [8*N-1:0] req_b,
    output logic           alu_begin,
    output logic [1:0]     alu_op,
    output logic [7:0]     alu_x,
    output logic [7:0]     alu_y,
    input  logic           alu_end,
    input  logic [15:0]    alu_res,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [15:0]    rsp_data,
    output logic           rsp_err,
    output logic           busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [CW-1:0]  r_cnt;
    logic           r_begin;
    logic [1:0]     r_op;
    logic [7:0]     r_x;
    logic [7:0]     r_y;
    logic           r_rsp_valid;
    logic [15:0]    r_rsp_data;
    logic           r_rsp_err;
    logic           r_busy;

    logic           w_found;
    logic [N-1:0]   w_grant;
    logic [IDW-1:0] w_gid;
    logic [IDW-1:0] w_idx;
    logic [1:0]     w_op;
    logic [7:0]     w_a;
    logic [7:0]     w_b;
    logic           w_div0;

    // Search starts just after the last served requester, wrapping at N.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_gid   = '0;
        w_idx   = '0;
        w_op    = '0;
        w_a     = '0;
        w_b     = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % N);
            if (!w_found && req_valid[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_gid          = w_idx;
                w_op           = req_op[{w_idx, 1'b0} +: 2];
                w_a            = req_a[{w_idx, 3'b000} +: 8];
                w_b            = req_b[{w_idx, 3'b000} +: 8];
            end
        end
    end

    assign w_div0 = (w_op == 2'b11) && (w_b == 8'h00);

    // Grant is only offered while idle and out of reset.
    assign req_ready = (r_state == S_IDLE && reset) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= IDW'(N - 1);
            r_id        <= '0;
            r_cnt       <= '0;
            r_begin     <= 1'b0;
            r_op        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id   <= w_gid;
                        r_op   <= w_op;
                        r_x    <= w_a;
                        r_y    <= w_b;
                        r_busy <= 1'b1;
                        if (w_div0) begin
                            // Divide-by-zero never reaches the ALU.
                            r_rsp_data  <= 16'hFFFF;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_begin <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_begin <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done pulse on the last watchdog cycle still wins.
                    if (alu_end) begin
                        r_rsp_data  <= r_op[1] ? alu_res
                                               : {8'h00, alu_res[7:0]};
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_ptr       <= r_id;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_begin = r_begin;
    assign alu_op    = r_op;
    assign alu_x     = r_x;
    assign alu_y     = r_y;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule
